// File: rtl/sum_collector_pkg.sv
// Shared widths and types for the sum collector: default operand/accumulator
// widths, the accumulator ceiling and the sum type.
package sum_collector_pkg;

    localparam int DEF_SUM_W = 5;
    localparam int DEF_ACC_W = 8;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

    typedef logic [DEF_SUM_W-1:0] sum_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata presents the head whenever not empty
// and reads as zero when empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sum_collector.sv
// Captures each new upstream sum on the rising edge of done, queues it, and
// keeps a saturating running total of every sum that made it into the queue.
module sum_collector
    import sum_collector_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SUM_W = DEF_SUM_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done,
    input  logic [SUM_W-1:0]       s,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [ACC_W-1:0]       acc,
    output logic                   acc_sat
);

    localparam logic [ACC_W-1:0] ACC_LIM = {ACC_W{1'b1}};

    logic             done_q;
    logic             capture, push, pop, empty;
    logic             overflow_q, overflow_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_sat_q, acc_sat_d;
    logic [ACC_W:0]   acc_sum;

    // Handshake: a word transfers on every posedge where out_valid and
    // out_ready are both high; out_data holds steady while valid waits on ready.
    assign capture = done & ~done_q;
    assign pop     = out_valid & out_ready;
    assign push    = capture & (~full | pop);

    assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, s};

    always_comb begin
        overflow_d = overflow_q | (capture & full & ~pop);
        acc_d      = acc_q;
        acc_sat_d  = acc_sat_q;
        if (acc_clr) begin
            acc_d     = push ? {{(ACC_W - SUM_W){1'b0}}, s} : '0;
            acc_sat_d = 1'b0;
        end else if (push) begin
            if (acc_sum[ACC_W]) begin
                acc_d     = ACC_LIM;
                acc_sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    // done_q resets high so a done level already asserted is not a new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b1;
            overflow_q <= 1'b0;
            acc_q      <= '0;
            acc_sat_q  <= 1'b0;
        end else begin
            done_q     <= done;
            overflow_q <= overflow_d;
            acc_q      <= acc_d;
            acc_sat_q  <= acc_sat_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (SUM_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (s),
        .rdata (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = ~empty;
    assign overflow  = overflow_q;
    assign acc       = acc_q;
    assign acc_sat   = acc_sat_q;

endmodule

// File: tb/tb_sum_collector.sv
// Directed bench for sum_collector: edge capture, FIFO order and full/pop
// corner, overflow, saturating accumulator, clear and mid-run reset.
module tb_sum_collector;
    import sum_collector_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    sum_t       s;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    sum_t       out_data;
    logic [2:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] acc;
    logic       acc_sat;

    int n_chk  = 0;
    int n_pass = 0;

    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    sum_collector #(.DEPTH(4), .SUM_W(5), .ACC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .s         (s),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .acc       (acc),
        .acc_sat   (acc_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One upstream result: done low for a cycle, then high with the sum.
    task automatic cap(input logic [4:0] val);
        done = 1'b0;
        tick();
        done = 1'b1;
        s    = val;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_acc();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_data"}, out_data, exp_q.pop_front());
            tick();
        end
        out_ready = 1'b0;
        chk({tag, "_empty"}, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; done = 1'b1; s = '0; acc_clr = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_acc", acc, 0);
        chk("rst_sat", acc_sat, 0);
        rst = 1'b0;

        // done held high across reset release: no capture
        repeat (5) tick();
        chk("hold_count", count, 0);
        chk("hold_valid", out_valid, 0);
        chk("hold_acc", acc, 0);

        // out_ready while empty must not underflow
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_pop_count", count, 0);

        // single capture, one-cycle latency
        cap(5'd17);
        chk("cap_valid", out_valid, 1);
        chk("cap_data", out_data, 17);
        chk("cap_count", count, 1);
        chk("cap_acc", acc, 17);
        repeat (3) tick();
        chk("long_done_count", count, 1);
        exp_q.push_back(5'd17);
        drain_check("single");
        clear_acc();
        chk("clr_acc", acc, 0);

        // fill, overflow on fifth, drain in order
        cap(5'd3);  exp_q.push_back(5'd3);
        cap(5'd9);  exp_q.push_back(5'd9);
        cap(5'd30); exp_q.push_back(5'd30);
        cap(5'd1);  exp_q.push_back(5'd1);
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_ovf", overflow, 0);
        cap(5'd7);
        chk("drop_ovf", overflow, 1);
        chk("drop_count", count, 4);
        chk("drop_acc", acc, 43);
        chk("stable_head", out_data, 3);
        drain_check("order");
        chk("ovf_sticky", overflow, 1);

        // full with simultaneous pop accepts the new sum
        do_reset();
        cap(5'd10); cap(5'd11); cap(5'd12); cap(5'd13);
        chk("full2", full, 1);
        done = 1'b0;
        tick();
        done = 1'b1; s = 5'd2; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fp_count", count, 4);
        chk("fp_ovf", overflow, 0);
        chk("fp_head", out_data, 11);
        chk("fp_acc", acc, 48);
        exp_q.push_back(5'd11); exp_q.push_back(5'd12);
        exp_q.push_back(5'd13); exp_q.push_back(5'd2);
        drain_check("fp");

        // saturation: 30 x 9 = 270 clamps at 255
        clear_acc();
        out_ready = 1'b1;
        repeat (8) cap(5'd30);
        chk("pre_sat_acc", acc, 240);
        chk("pre_sat_flag", acc_sat, 0);
        cap(5'd30);
        chk("sat_acc", acc, 255);
        chk("sat_flag", acc_sat, 1);
        cap(5'd1);
        chk("sat_hold", acc, 255);
        // clear with simultaneous accepted capture
        done = 1'b0;
        tick();
        done = 1'b1; s = 5'd4; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clrcap_acc", acc, 4);
        chk("clrcap_sat", acc_sat, 0);
        tick(); tick();
        out_ready = 1'b0;
        chk("sat_drained", out_valid, 0);

        // mid-run reset with count=3, overflow=1, acc=50
        clear_acc();
        cap(5'd10); cap(5'd10); cap(5'd10); cap(5'd20);
        cap(5'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_rst_count", count, 3);
        chk("pre_rst_ovf", overflow, 1);
        chk("pre_rst_acc", acc, 50);
        do_reset();
        chk("mrst_count", count, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_acc", acc, 0);
        chk("mrst_data", out_data, 0);
        tick(); tick();
        chk("mrst_norecap", count, 0);
        cap(5'd6);
        chk("post_valid", out_valid, 1);
        chk("post_data", out_data, 6);
        chk("post_count", count, 1);
        chk("post_acc", acc, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
